// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the approximate half-adder-array multiplier.
// Optional error monitor in the top is enabled by APPROX_ERR_MON_EN.
package approx_mul_pkg;

    typedef enum logic {
        CELL_HA = 1'b0,
        CELL_OR = 1'b1
    } cell_mode_e;

    function automatic int pair_count(input int w);
        return w / 2;
    endfunction

    // Columns strictly below the threshold drop their carry and keep only the OR.
    function automatic cell_mode_e cell_mode(input int g, input int k);
        return (g < k) ? CELL_OR : CELL_HA;
    endfunction

endpackage

// File: rtl/approx_ha_mul_pipe_pair.sv
// One HA array compressing partial-product rows 2i and 2i+1 into a sum
// vector t (weight BASE) and a carry vector b_vec (weight BASE+2).
module approx_ha_pair
    import approx_mul_pkg::*;
#(
    parameter int W    = 8,
    parameter int KW   = $clog2(2 * W),
    parameter int BASE = 0
) (
    input  logic [W-1:0]  row_a,
    input  logic [W-1:0]  row_b,
    input  logic [KW-1:0] cfg_k,
    output logic [W:0]    t,
    output logic [W-2:0]  b_vec
);

    always_comb begin
        t        = '0;
        b_vec    = '0;
        t[0]     = row_a[0];
        for (int j = 1; j < W; j++) begin
            if (cell_mode(BASE + j, int'(cfg_k)) == CELL_OR) begin
                t[j] = row_a[j] | row_b[j-1];
            end else begin
                t[j] = row_a[j] ^ row_b[j-1];
                // The top column's carry extends t rather than b_vec.
                if (j < W - 1) b_vec[j-1] = row_a[j] & row_b[j-1];
                else           t[W]       = row_a[j] & row_b[j-1];
            end
        end
        b_vec[W-2] = row_b[W-1];
    end

endmodule

// File: rtl/approx_ha_mul_pipe.sv
// Two-stage elastic approximate multiplier: S1 registers the HA-array outputs,
// S2 sums them into p. APPROX_ERR_MON_EN adds an accumulated-error monitor.
module approx_ha_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int W  = 8,
    parameter int KW = $clog2(2 * W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    x,
    input  logic [W-1:0]    y,
    input  logic [KW-1:0]   cfg_k,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  p
`ifdef APPROX_ERR_MON_EN
    ,
    input  logic            err_clr,
    output logic [31:0]     err_acc
`endif
);

    localparam int NP = pair_count(W);
    localparam int PW = 2 * W;

    logic [W:0]   t_c  [NP];
    logic [W-2:0] b_c  [NP];
    logic [W:0]   s1_t [NP];
    logic [W-2:0] s1_b [NP];
    logic         s1_v;
    logic         s1_adv, s2_adv, in_xfer;
    logic [PW-1:0] sum_c;

    for (genvar i = 0; i < NP; i++) begin : g_pair
        approx_ha_pair #(
            .W    (W),
            .KW   (KW),
            .BASE (2 * i)
        ) u_pair (
            .row_a (y & {W{x[2*i]}}),
            .row_b (y & {W{x[2*i+1]}}),
            .cfg_k (cfg_k),
            .t     (t_c[i]),
            .b_vec (b_c[i])
        );
    end

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NP; i++) begin
            sum_c = sum_c + (PW'(s1_t[i]) << (2 * i)) + (PW'(s1_b[i]) << (2 * i + 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
            p         <= '0;
            for (int i = 0; i < NP; i++) begin
                s1_t[i] <= '0;
                s1_b[i] <= '0;
            end
        end else begin
            if (s1_adv) s1_v <= in_valid;
            if (in_xfer) begin
                for (int i = 0; i < NP; i++) begin
                    s1_t[i] <= t_c[i];
                    s1_b[i] <= b_c[i];
                end
            end
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) p <= sum_c;
            end
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [PW-1:0] s1_exact, s2_exact, err_diff;
    logic [32:0]   err_sum;

    assign err_diff = s2_exact - p;
    assign err_sum  = {1'b0, err_acc} + 33'(err_diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exact <= '0;
            s2_exact <= '0;
            err_acc  <= '0;
        end else begin
            if (in_xfer)          s1_exact <= PW'(x) * PW'(y);
            if (s2_adv && s1_v)   s2_exact <= s1_exact;
            if (err_clr)                     err_acc <= '0;
            else if (out_valid && out_ready) err_acc <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_approx_ha_mul_pipe.sv
// Directed/table-driven bench for approx_ha_mul_pipe at W=8.
module tb_approx_ha_mul_pipe;

    localparam int W  = 8;
    localparam int KW = 4;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic [KW-1:0] cfg_k = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] p;
`ifdef APPROX_ERR_MON_EN
    logic          err_clr = 1'b0;
    logic [31:0]   err_acc;
`endif

    approx_ha_mul_pipe #(.W(W), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cfg_k     (cfg_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_clr   (err_clr),
        .err_acc   (err_acc)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cell-by-cell weighted sum of the approximate array.
    function automatic logic [PW-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                            input logic [KW-1:0] kv);
        int acc = 0;
        for (int i = 0; i < W / 2; i++) begin
            acc += int'(xv[2*i] & yv[0]) << (2 * i);
            acc += int'(xv[2*i+1] & yv[W-1]) << (2 * i + W);
            for (int j = 1; j < W; j++) begin
                int a = int'(xv[2*i] & yv[j]);
                int b = int'(xv[2*i+1] & yv[j-1]);
                int g = 2 * i + j;
                if (g < int'(kv)) acc += (a | b) << g;
                else              acc += ((a ^ b) << g) + ((a & b) << (g + 1));
            end
        end
        return PW'(acc);
    endfunction

    typedef struct {
        logic [W-1:0]  xv;
        logic [W-1:0]  yv;
        logic [KW-1:0] kv;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs [10];
    logic [PW-1:0] q [$];

    initial begin
        int sent, got, acc, seen;
        logic prev_stall, acc_now;
        logic [PW-1:0] prev_p;
        logic [W-1:0] bp_x [3];

        vecs[0] = '{8'd255, 8'd255, 4'd0,  16'd65025};
        vecs[1] = '{8'd3,   8'd3,   4'd0,  16'd9};
        vecs[2] = '{8'd3,   8'd3,   4'd2,  16'd7};
        vecs[3] = '{8'd255, 8'd255, 4'd15, 16'd43435};
        vecs[4] = '{8'd255, 8'd255, 4'd14, 16'd43435};
        vecs[5] = '{8'd255, 8'd255, 4'd1,  16'd65025};
        vecs[6] = '{8'd0,   8'd255, 4'd9,  16'd0};
        vecs[7] = '{8'd200, 8'd0,   4'd15, 16'd0};
        vecs[8] = '{8'd0,   8'd0,   4'd15, 16'd0};
        vecs[9] = '{8'd12,  8'd10,  4'd0,  16'd120};

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
`ifdef APPROX_ERR_MON_EN
        check("rst_err_acc", err_acc, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1);

        // Table: each vector accepted, absent after one edge, present after the second.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            x = vecs[v].xv; y = vecs[v].yv; cfg_k = vecs[v].kv;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("lat_early_valid", out_valid, 0);
            @(posedge clk); #1;
            check("lat_valid", out_valid, 1);
            check("vec_p", p, vecs[v].exp);
        end

        // Random stream with random backpressure.
        @(negedge clk);
        in_valid = 1'b0;
        sent = 0; got = 0; prev_stall = 1'b0; prev_p = '0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20 && !in_valid) begin
                in_valid = 1'b1;
                x = 8'($urandom); y = 8'($urandom); cfg_k = 4'($urandom);
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_p", p, prev_p);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL stream_extra: got output %0d, expected none", p);
                end else begin
                    check("stream_p", p, q.pop_front());
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_p = p;
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                q.push_back(model(x, y, cfg_k));
                sent++;
            end
            @(posedge clk); #1;
            if (acc_now) in_valid = 1'b0;
        end
        check("stream_count", got, 20);
        check("stream_left", q.size(), 0);

        // Backpressure: only two entries fit, then drain in order.
        bp_x[0] = 8'd7; bp_x[1] = 8'd11; bp_x[2] = 8'd13;
        acc = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 3) begin
                x = bp_x[acc]; y = 8'd9; cfg_k = 4'd3; in_valid = 1'b1;
            end
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(x, y, cfg_k));
                acc++;
            end
            @(negedge clk);
        end
        check("bp_accepts", acc, 2);
        check("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (out_valid) check("bp_drain_p", p, q.pop_front());
            @(negedge clk);
        end
        check("bp_drain_left", q.size(), 0);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            x = 8'd100 + 8'(c); y = 8'd50; cfg_k = 4'd0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_output", seen, 0);

`ifdef APPROX_ERR_MON_EN
        check("err_after_rst", err_acc, 0);
        for (int v = 1; v <= 2; v++) begin
            x = vecs[v].xv; y = vecs[v].yv; cfg_k = vecs[v].kv; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        check("err_acc_3x3", err_acc, 2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", err_acc, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
